fft_transpose_buffer: RTL and testbench

Ping-pong corner-turn buffer between the two radix-4 passes of the 16-point FFT. It captures the four 136-bit stage-1 `butterfly` results of a frame and replays them transposed as four stage-2 `butterfly` input words, together with the matching stage-2 rotation code. Two banks let the next frame be written while the current one drains, so the datapath streams at one word per clock.

---
 rtl/fft_pkg.sv | 18 +
 rtl/tbuf_bank.sv | 34 +++
 rtl/fft_transpose_buffer.sv | 98 +++++++++
 tb/tb_fft_transpose_buffer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants and helpers for the 16-point radix-4 FFT datapath.
package fft_pkg;

  localparam int SAMPLE_W = 17;            // sign, 8 integer bits, 8 fraction bits
  localparam int CPLX_W   = 2 * SAMPLE_W;  // {Re, Im}
  localparam int BUS_W    = 4 * CPLX_W;    // four complex samples per word
  localparam int RADIX    = 4;

  // Stage-2 rotation codes are {1'b1, k[1:0]}
  localparam logic [2:0] STAGE2_ROT_BASE = 3'b100;

  // Extract complex sample idx from a four-sample bus word (slice 0 in the LSBs)
  function automatic logic [CPLX_W-1:0] get_slice(input logic [BUS_W-1:0] word,
                                                  input logic [1:0]       idx);
    return word[idx*CPLX_W +: CPLX_W];
  endfunction

endpackage

// File: rtl/tbuf_bank.sv
// One corner-turn bank: four rows written whole, read back one column at a time.
// Column col returns slice col of every row, with row 0 in the LSBs.
module tbuf_bank
  import fft_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [1:0]       row,
  input  logic [BUS_W-1:0] wdata,
  input  logic [1:0]       col,
  output logic [BUS_W-1:0] col_data
);

  logic [BUS_W-1:0] rows [RADIX];

  genvar gi;
  generate
    for (gi = 0; gi < RADIX; gi++) begin : g_row
      // Capture a full stage-1 word into row gi when it is the addressed row
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rows[gi] <= '0;
        end else if (we && (row == 2'(gi))) begin
          rows[gi] <= wdata;
        end
      end

      // Transposed read: output slice gi comes from row gi, column col
      assign col_data[gi*CPLX_W +: CPLX_W] = get_slice(rows[gi], col);
    end
  endgenerate

endmodule

// File: rtl/fft_transpose_buffer.sv
// Ping-pong corner-turn buffer between the two radix-4 FFT passes.
// Four stage-1 words fill one bank while the other bank drains transposed.
// SAMPLE_W must match fft_pkg::SAMPLE_W; the banks are sized from the package.
module fft_transpose_buffer #(
  parameter int SAMPLE_W = 17
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*SAMPLE_W-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*SAMPLE_W-1:0] out_data,
  output logic [2:0]            rot_out,
  output logic                  out_last
);

  import fft_pkg::*;

  logic [1:0] full;        // bank holds a complete frame (until its last word leaves)
  logic [1:0] full_next;
  logic       wb;          // bank being written
  logic       rb;          // bank being drained
  logic [1:0] wc;          // row to write next
  logic [1:0] rc;          // column to read next
  logic       accept;
  logic       xfer;
  logic [1:0] bank_we;
  logic [8*SAMPLE_W-1:0] col_data [2];

  // Handshakes depend only on registered state, so no input-to-output paths
  assign in_ready  = !full[wb];
  assign accept    = in_valid && in_ready;
  assign out_valid = full[rb];
  assign xfer      = out_valid && out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      assign bank_we[gi] = accept && (wb == 1'(gi));

      tbuf_bank u_bank (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (bank_we[gi]),
        .row      (wc),
        .wdata    (in_data),
        .col      (rc),
        .col_data (col_data[gi])
      );
    end
  endgenerate

  // Output word is the current column of the draining bank; stable while stalled
  assign out_data = col_data[rb];
  assign rot_out  = STAGE2_ROT_BASE | {1'b0, rc};
  assign out_last = out_valid && (rc == 2'd3);

  // Flag update: the write side sets, the read side clears; they never hit the same bank
  always_comb begin
    full_next = full;
    if (accept && (wc == 2'd3)) full_next[wb] = 1'b1;
    if (xfer && (rc == 2'd3))   full_next[rb] = 1'b0;
  end

  // Full flags register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= '0;
    end else begin
      full <= full_next;
    end
  end

  // Write pointer and row counter: a frame is committed on its fourth accepted word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb <= 1'b0;
      wc <= 2'd0;
    end else if (accept) begin
      wc <= wc + 2'd1;
      if (wc == 2'd3) wb <= ~wb;
    end
  end

  // Read pointer and column counter: a bank is released after its fourth transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb <= 1'b0;
      rc <= 2'd0;
    end else if (xfer) begin
      rc <= rc + 2'd1;
      if (rc == 2'd3) rb <= ~rb;
    end
  end

endmodule

// File: tb/tb_fft_transpose_buffer.sv
// Randomized self-checking bench for fft_transpose_buffer against a queue-based frame model.
module tb_fft_transpose_buffer;

  localparam int SW = 17;
  localparam int CW = 2 * SW;
  localparam int W  = 8 * SW;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [2:0]   rot_out;
  logic         out_last;

  fft_transpose_buffer #(.SAMPLE_W(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .rot_out   (rot_out),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int dut_acc = 0;
  bit pat_chk = 1'b0;

  // Reference model: every accepted word in order; each group of 4 is a frame.
  // A frame occupies a bank until its 4th output word has been transferred.
  logic [W-1:0] mq[$];
  int           dcnt = 0;

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Output word k of the front frame: slice j comes from input word j, slice k
  function automatic logic [W-1:0] exp_word(input int k);
    logic [W-1:0] r;
    r = '0;
    for (int j = 0; j < 4; j++) r[j*CW +: CW] = mq[j][k*CW +: CW];
    return r;
  endfunction

  // Word w, slice s: Re = 4w+s, Im = -(4w+s)
  function automatic logic [W-1:0] pattern(input int w);
    logic [W-1:0] r;
    int v;
    r = '0;
    for (int s = 0; s < 4; s++) begin
      v = 4 * w + s;
      r[s*CW +: CW] = {SW'(v), SW'(-v)};
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock: drive at negedge, compare before the rising edge, then advance the model
  task automatic cycle(input logic iv, input logic [W-1:0] d, input logic ordy);
    logic e_ready, e_valid, acc, xf;
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
    e_ready = (mq.size() / 4) < 2;
    e_valid = (mq.size() / 4) > 0;
    check_val("in_ready", W'(in_ready), W'(e_ready));
    check_val("out_valid", W'(out_valid), W'(e_valid));
    if (e_valid) begin
      check_val("out_data", out_data, exp_word(dcnt));
      check_val("rot_out", W'(rot_out), W'({1'b1, 2'(dcnt)}));
      check_val("out_last", W'(out_last), W'(dcnt == 3));
      if (pat_chk)
        for (int j = 0; j < 4; j++)
          check_val("pattern_re", W'(out_data[j*CW + SW +: SW]), W'(SW'(4 * j + dcnt)));
    end else begin
      check_val("out_last_idle", W'(out_last), W'(0));
    end
    if (iv && in_ready) dut_acc++;
    acc = iv && e_ready;
    xf  = e_valid && ordy;
    @(posedge clk);
    if (xf) begin
      dcnt++;
      if (dcnt == 4) begin
        repeat (4) void'(mq.pop_front());
        dcnt = 0;
      end
    end
    if (acc) mq.push_back(d);
  endtask

  // Asynchronous reset pulse away from the clock edge; outputs must react at once
  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_in_ready", W'(in_ready), W'(1));
    check_val("rst_out_valid", W'(out_valid), W'(0));
    check_val("rst_out_last", W'(out_last), W'(0));
    check_val("rst_out_data", out_data, '0);
    check_val("rst_rot_out", W'(rot_out), W'(3'b100));
    mq.delete();
    dcnt = 0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Single frame with the reference pattern
    pat_chk = 1'b1;
    for (int w = 0; w < 4; w++) cycle(1'b1, pattern(w), 1'b1);
    drain(6);
    pat_chk = 1'b0;

    // Three frames back to back at full rate
    for (int i = 0; i < 12; i++) cycle(1'b1, rand_word(), 1'b1);
    drain(10);

    // Input gap of three cycles between words 1 and 2
    pat_chk = 1'b1;
    cycle(1'b1, pattern(0), 1'b1);
    cycle(1'b1, pattern(1), 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, rand_word(), 1'b1);
    cycle(1'b1, pattern(2), 1'b1);
    cycle(1'b1, pattern(3), 1'b1);
    drain(6);
    pat_chk = 1'b0;

    // Backpressure: exactly two frames fit, then release
    dut_acc = 0;
    for (int i = 0; i < 11; i++) cycle(1'b1, rand_word(), 1'b0);
    check_val("bp_accepted", W'(dut_acc), W'(8));
    for (int i = 0; i < 6; i++) cycle(1'b1, rand_word(), 1'b1);
    drain(12);

    // Random stalls during drain, then fully random traffic
    for (int i = 0; i < 8; i++) cycle(1'b1, rand_word(), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 30; i++) cycle(1'b0, '0, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 200; i++)
      cycle(1'($urandom_range(0, 1)), rand_word(), 1'($urandom_range(0, 3) != 0));
    drain(12);

    // Reset with frame 1 half drained and frame 2 partially written
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, rand_word(), 1'b0);
    cycle(1'b1, rand_word(), 1'b1);
    cycle(1'b1, rand_word(), 1'b1);
    cycle(1'b1, rand_word(), 1'b0);
    do_reset();
    pat_chk = 1'b1;
    for (int w = 0; w < 4; w++) cycle(1'b1, pattern(w), 1'b0);
    drain(6);
    pat_chk = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
